// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor. It resolves one BLOCK-bit CLA group per stage
// and registers the group carry between stages. It has a valid/ready handshake with
// backpressure and registered ALU status flags.
module pipelined_cla_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    // Guarded divisor so a bad BLOCK reports the check below instead of a divide-by-zero.
    localparam int unsigned BlkSafe = (BLOCK < 1) ? 1 : BLOCK;
    localparam int unsigned N       = WIDTH / BlkSafe;

    if ((BLOCK < 1) || ((WIDTH % BlkSafe) != 0)) begin : g_bad_params
        $error("pipelined_cla_addsub: WIDTH must be a non-zero multiple of BLOCK >= 1");
    end

    // One CLA group: returns {carry out, carry into group MSB, sum bits}. Each carry is the
    // flattened generate/propagate sum-of-products, so nothing ripples inside the group.
    function automatic logic [BLOCK+1:0] cla_group(input logic [BLOCK-1:0] ga,
                                                   input logic [BLOCK-1:0] gb,
                                                   input logic             gc);
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   c;
        logic             t;
        p = ga ^ gb;
        g = ga & gb;
        for (int j = 0; j <= int'(BLOCK); j++) begin
            t = gc;
            for (int i = 0; i < j; i++) t = t & p[i];
            c[j] = t;
            for (int i = 0; i < j; i++) begin
                t = g[i];
                for (int m = i + 1; m < j; m++) t = t & p[m];
                c[j] = c[j] | t;
            end
        end
        return {c[BLOCK], c[BLOCK-1], p ^ c[BLOCK-1:0]};
    endfunction

    // Stage registers S1..SN (index 0..N-1).
    logic             valid_q [N];
    logic [WIDTH-1:0] res_q   [N];
    logic [WIDTH-1:0] a_q     [N];
    logic [WIDTH-1:0] b_q     [N];
    logic             c_q     [N];
    logic             cmsb_q;
    logic             zero_q;

    logic             valid_d [N];
    logic [WIDTH-1:0] res_d   [N];
    logic [WIDTH-1:0] a_d     [N];
    logic [WIDTH-1:0] b_d     [N];
    logic             c_d     [N];
    logic [BLOCK+1:0] grp     [N];
    logic             cmsb_d;
    logic             zero_d;
    logic [WIDTH-1:0] b_eff;
    logic             advance;

    assign advance = out_ready | ~valid_q[N-1];
    assign b_eff   = sub ? ~b : b;

    // Next-state of every stage: stage 0 takes preprocessed operands, stage k resolves group k.
    always_comb begin
        grp[0]     = cla_group(a[0 +: BLOCK], b_eff[0 +: BLOCK], sub ^ cin);
        valid_d[0] = in_valid;
        a_d[0]     = a;
        b_d[0]     = b_eff;
        c_d[0]     = grp[0][BLOCK+1];
        res_d[0]   = '0;
        res_d[0][0 +: BLOCK] = grp[0][BLOCK-1:0];
        for (int k = 1; k < int'(N); k++) begin
            grp[k]     = cla_group(a_q[k-1][k*BLOCK +: BLOCK], b_q[k-1][k*BLOCK +: BLOCK],
                                   c_q[k-1]);
            valid_d[k] = valid_q[k-1];
            a_d[k]     = a_q[k-1];
            b_d[k]     = b_q[k-1];
            c_d[k]     = grp[k][BLOCK+1];
            res_d[k]   = res_q[k-1];
            res_d[k][k*BLOCK +: BLOCK] = grp[k][BLOCK-1:0];
        end
        cmsb_d = grp[N-1][BLOCK];
        zero_d = ~|res_d[N-1];
    end

    // Shift the whole pipe on advance, hold everything otherwise; reset clears all state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(N); k++) begin
                valid_q[k] <= 1'b0;
                res_q[k]   <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                c_q[k]     <= 1'b0;
            end
            cmsb_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < int'(N); k++) begin
                valid_q[k] <= valid_d[k];
                res_q[k]   <= res_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                c_q[k]     <= c_d[k];
            end
            cmsb_q <= cmsb_d;
            zero_q <= zero_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = valid_q[N-1];
    assign r         = res_q[N-1];
    assign cout      = c_q[N-1];
    assign ovf       = cmsb_q ^ c_q[N-1];
    assign zero      = zero_q;
    assign neg       = res_q[N-1][WIDTH-1];

endmodule
